// File: rtl/swizzle_dram_to_cram.sv
// swizzle_dram_to_cram: corner-turns DWIDTH x DWIDTH tiles from DRAM rows into CRAM bit-columns via ping/pong buffers.
// Define SWIZZLE_DMA_BYPASS_EN to add dma_mode_i, which stores rows untransposed.
module swizzle_dram_to_cram #(
    parameter int DWIDTH     = 40,
    parameter int MEM_AWIDTH = 9,
    parameter int RAM_AWIDTH = 9,
    parameter int TWIDTH     = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
`ifdef SWIZZLE_DMA_BYPASS_EN
    input  logic                  dma_mode_i,
`endif
    input  logic                  start_i,
    input  logic [TWIDTH-1:0]     num_tiles_i,
    input  logic [MEM_AWIDTH-1:0] mem_ctrl_addr_start_i,
    input  logic [RAM_AWIDTH-1:0] ram_addr_start_i,
    output logic                  mem_ctrl_re_o,
    output logic [MEM_AWIDTH-1:0] mem_ctrl_addr_o,
    input  logic                  mem_ctrl_rvalid_i,
    input  logic [DWIDTH-1:0]     mem_ctrl_data_in_i,
    output logic                  ram_we_o,
    input  logic                  ram_ready_i,
    output logic [RAM_AWIDTH-1:0] ram_addr_o,
    output logic [DWIDTH-1:0]     ram_data_out_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int CW = $clog2(DWIDTH);
    localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);
    typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT} l_state_t;
    typedef enum logic {U_IDLE, U_WRITE} u_state_t;
    l_state_t               l_state_q;
    u_state_t               u_state_q;
    logic                   busy_q, done_q, re_q, we_q, dma_q;
    logic                   load_ptr_q, unload_ptr_q;
    logic [1:0]             full_q;
    logic [TWIDTH-1:0]      tiles_req_q, tiles_left_q;
    logic [MEM_AWIDTH-1:0]  mem_addr_q;
    logic [RAM_AWIDTH-1:0]  ram_addr_q;
    logic [CW-1:0]          req_cnt_q, rv_cnt_q, col_q;
    logic [DWIDTH-1:0]      data_q;
    logic [DWIDTH-1:0]      buf_q [2][DWIDTH];
    logic                   accept, last_col, rv_take, sel_d;
    logic [CW-1:0]          col_d;
    logic [DWIDTH-1:0]      word_d;
    assign accept   = we_q && ram_ready_i;
    assign last_col = col_q == LAST;
    assign rv_take  = mem_ctrl_rvalid_i && l_state_q != L_IDLE;
    // Next word to present: following column, or column 0 of the other buffer after a tile ends.
    always_comb begin
        sel_d = (accept && last_col) ? ~unload_ptr_q : unload_ptr_q;
        col_d = (accept && !last_col) ? col_q + 1'b1 : '0;
        for (int i = 0; i < DWIDTH; i++)
            word_d[i] = dma_q ? buf_q[sel_d][col_d][i] : buf_q[sel_d][i][col_d];
    end
`ifdef SWIZZLE_DMA_BYPASS_EN
    always_ff @(posedge clk_i)
        dma_q <= reset_i ? 1'b0 : (start_i && !busy_q) ? dma_mode_i : dma_q;
`else
    assign dma_q = 1'b0;
`endif
    always_ff @(posedge clk_i)
        if (rv_take) buf_q[load_ptr_q][rv_cnt_q] <= mem_ctrl_data_in_i;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            l_state_q    <= L_IDLE;
            u_state_q    <= U_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            load_ptr_q   <= 1'b0;
            unload_ptr_q <= 1'b0;
            full_q       <= '0;
            tiles_req_q  <= '0;
            tiles_left_q <= '0;
            mem_addr_q   <= '0;
            ram_addr_q   <= '0;
            req_cnt_q    <= '0;
            rv_cnt_q     <= '0;
            col_q        <= '0;
            data_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q       <= num_tiles_i != '0;
                done_q       <= num_tiles_i == '0;
                tiles_req_q  <= num_tiles_i;
                tiles_left_q <= num_tiles_i;
                mem_addr_q   <= mem_ctrl_addr_start_i;
                ram_addr_q   <= ram_addr_start_i;
            end
            case (l_state_q)
                L_IDLE: if (tiles_req_q != '0 && !full_q[load_ptr_q]) begin
                    l_state_q <= L_REQ;
                    re_q      <= 1'b1;
                    req_cnt_q <= '0;
                end
                L_REQ: begin
                    mem_addr_q <= mem_addr_q + 1'b1;
                    req_cnt_q  <= req_cnt_q + 1'b1;
                    if (req_cnt_q == LAST) begin
                        re_q        <= 1'b0;
                        l_state_q   <= L_WAIT;
                        tiles_req_q <= tiles_req_q - 1'b1;
                    end
                end
                default: ;
            endcase
            if (rv_take) begin
                rv_cnt_q <= (rv_cnt_q == LAST) ? '0 : rv_cnt_q + 1'b1;
                if (rv_cnt_q == LAST) begin
                    full_q[load_ptr_q] <= 1'b1;
                    load_ptr_q         <= ~load_ptr_q;
                    l_state_q          <= L_IDLE;
                end
            end
            if (u_state_q == U_IDLE && full_q[unload_ptr_q]) begin
                u_state_q <= U_WRITE;
                we_q      <= 1'b1;
            end
            if (accept || (u_state_q == U_IDLE && full_q[unload_ptr_q])) data_q <= word_d;
            if (accept) begin
                ram_addr_q <= ram_addr_q + 1'b1;
                col_q      <= col_d;
                if (last_col) begin
                    full_q[unload_ptr_q] <= 1'b0;
                    unload_ptr_q         <= ~unload_ptr_q;
                    tiles_left_q         <= tiles_left_q - 1'b1;
                    if (tiles_left_q == TWIDTH'(1) || !full_q[~unload_ptr_q]) begin
                        we_q      <= 1'b0;
                        u_state_q <= U_IDLE;
                    end
                    if (tiles_left_q == TWIDTH'(1)) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
            end
        end
    end
    assign mem_ctrl_re_o   = re_q;
    assign mem_ctrl_addr_o = mem_addr_q;
    assign ram_we_o        = we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_data_out_o  = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
endmodule
